// File: rtl/smem_bck_writeback_pkg.sv
// Shared constants for the backward-extension writeback stage: token status codes,
// default widths, FSM state encoding and the feedback token layout.
package smem_bck_writeback_pkg;

   localparam int unsigned DefAddrW = 7;
   localparam int unsigned DefIntvW = 32;

   localparam logic [5:0] BCK_INI = 6'h04;
   localparam logic [5:0] BCK_RUN = 6'h05;
   localparam logic [5:0] BCK_END = 6'h06;
   localparam logic [5:0] BUBBLE  = 6'h30;
   localparam logic [5:0] DONE    = 6'h3f;

   localparam logic [1:0] StRun    = 2'd0;
   localparam logic [1:0] StDrain  = 2'd1;
   localparam logic [1:0] StReport = 2'd2;

   typedef struct packed {
      logic [5:0] status;
      logic [8:0] read_num;
      logic [6:0] backward_i;
      logic [6:0] backward_j;
      logic [6:0] new_size;
      logic [6:0] new_last_size;
      logic [6:0] current_wr_addr;
      logic [6:0] mem_wr_addr;
      logic [6:0] min_intv;
      logic       iteration_boundary;
   } fb_tok_t;

   localparam fb_tok_t IdleTok = '{status: BUBBLE, default: '0};

endpackage

// File: rtl/smem_bck_writeback_if.sv
// Write channel from the writeback stage toward the on-chip interval buffer.
interface smem_bck_writeback_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned INTV_W = 32
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_W-1:0]     wr_addr;
   logic [3*INTV_W-1:0]   wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/smem_wb_fifo.sv
// Synchronous FIFO with occupancy count, full/almost-full flags and a sticky overflow flag.
// The head entry is presented directly from the storage registers.
module smem_wb_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [Width-1:0]           data_i,
   input  logic                       pop_i,
   output logic                       valid_o,
   output logic [Width-1:0]           data_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic                       overflow_o
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q, count_d;
   logic             overflow_q;
   logic             do_push, do_pop;

   assign valid_o       = (count_q != '0);
   assign data_o        = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o       = count_q;
   assign full_o        = (count_q == DepthC);
   assign almost_full_o = (count_q >= DepthC - 1'b1);
   assign overflow_o    = overflow_q;

   assign do_pop  = pop_i & valid_o;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push_i && !do_push) overflow_q <= 1'b1;
      end
   end

endmodule

// File: rtl/smem_bck_writeback.sv
// Backward-extension loop tail: keep/drop decision, interval write FIFO, feedback token and
// drain/report sequencing. Optional duplicate suppression under macro BCK_WB_DEDUP_EN.
module smem_bck_writeback
   import smem_bck_writeback_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned INTV_W     = DefIntvW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   output logic              stall_out,
   input  logic [5:0]        status_q,
   input  logic [8:0]        read_num_q,
   input  logic [6:0]        backward_i_q,
   input  logic [6:0]        backward_j_q,
   input  logic [6:0]        new_size_q,
   input  logic [6:0]        new_last_size_q,
   input  logic [6:0]        current_wr_addr_q,
   input  logic [6:0]        mem_wr_addr_q,
   input  logic [6:0]        min_intv_q,
   input  logic              finish_sign_q,
   input  logic              iteration_boundary_q,
   input  logic [INTV_W-1:0] ext_k,
   input  logic [INTV_W-1:0] ext_l,
   input  logic [INTV_W-1:0] ext_s,
   output logic              fb_valid,
   output logic [5:0]        fb_status,
   output logic [8:0]        fb_read_num,
   output logic [6:0]        fb_backward_i,
   output logic [6:0]        fb_backward_j,
   output logic [6:0]        fb_new_size,
   output logic [6:0]        fb_new_last_size,
   output logic [6:0]        fb_current_wr_addr,
   output logic [6:0]        fb_mem_wr_addr,
   output logic [6:0]        fb_min_intv,
   output logic              fb_iteration_boundary,
   smem_bck_writeback_if.master wr_if,
   output logic              done_valid,
   output logic [8:0]        done_read_num,
   output logic [6:0]        done_count,
   output logic              err_overflow
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EntW = ADDR_W + 3 * INTV_W;

   fb_tok_t         fb_q, fb_d, in_tok;
   logic            fb_valid_q, fb_valid_d;
   logic [1:0]      state_q, state_d;
   logic [8:0]      done_rn_q, done_rn_d;
   logic [6:0]      done_cnt_q, done_cnt_d;
   logic            keep, dup, push;
   logic [EntW-1:0] fifo_data;
   logic [CntW-1:0] fifo_cnt;
   logic            fifo_full, fifo_afull;

   smem_wb_fifo #(
      .Depth(FIFO_DEPTH),
      .Width(EntW)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .data_i       ({ADDR_W'(current_wr_addr_q), ext_k, ext_l, ext_s}),
      .pop_i        (wr_if.wr_ready),
      .valid_o      (wr_if.wr_valid),
      .data_o       (fifo_data),
      .count_o      (fifo_cnt),
      .full_o       (fifo_full),
      .almost_full_o(fifo_afull),
      .overflow_o   (err_overflow)
   );

   assign wr_if.wr_addr = fifo_data[3*INTV_W +: ADDR_W];
   assign wr_if.wr_data = fifo_data[3*INTV_W-1:0];

`ifdef BCK_WB_DEDUP_EN
   logic [INTV_W-1:0] last_s_q;
   logic [8:0]        last_rn_q;
   logic              last_vld_q;
   logic              accept;

   assign accept = ~stall_in & (state_q == StRun);
   assign dup    = last_vld_q & (last_rn_q == read_num_q) & (last_s_q == ext_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_s_q   <= '0;
         last_rn_q  <= '0;
         last_vld_q <= 1'b0;
      end else if (accept && (status_q == BCK_INI || iteration_boundary_q)) begin
         last_vld_q <= 1'b0;
      end else if (push) begin
         last_s_q   <= ext_s;
         last_rn_q  <= read_num_q;
         last_vld_q <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      keep   = (ext_s >= INTV_W'(min_intv_q)) & ~iteration_boundary_q & ~dup;
      in_tok = '{status: status_q, read_num: read_num_q, backward_i: backward_i_q,
                 backward_j: backward_j_q, new_size: new_size_q,
                 new_last_size: new_last_size_q, current_wr_addr: current_wr_addr_q,
                 mem_wr_addr: mem_wr_addr_q, min_intv: min_intv_q,
                 iteration_boundary: iteration_boundary_q};
      fb_d       = fb_q;
      fb_valid_d = fb_valid_q;
      state_d    = state_q;
      done_rn_d  = done_rn_q;
      done_cnt_d = done_cnt_q;
      push       = 1'b0;
      if (!stall_in) begin
         fb_d       = IdleTok;
         fb_valid_d = 1'b0;
         unique case (state_q)
            StRun: begin
               if (status_q == BCK_INI) begin
                  fb_d       = in_tok;
                  fb_valid_d = 1'b1;
               end else if (status_q == BCK_RUN) begin
                  fb_d       = in_tok;
                  fb_valid_d = 1'b1;
                  if (keep) begin
                     push                 = 1'b1;
                     fb_d.new_size        = new_size_q + 7'd1;
                     fb_d.current_wr_addr = current_wr_addr_q - 7'd1;
                  end
                  if (finish_sign_q) begin
                     state_d    = StDrain;
                     done_rn_d  = read_num_q;
                     done_cnt_d = fb_d.new_size;
                  end
               end
            end
            StDrain:  if (fifo_cnt == '0) state_d = StReport;
            StReport: state_d = StRun;
            default:  state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb_q       <= IdleTok;
         fb_valid_q <= 1'b0;
         state_q    <= StRun;
         done_rn_q  <= '0;
         done_cnt_q <= '0;
      end else begin
         fb_q       <= fb_d;
         fb_valid_q <= fb_valid_d;
         state_q    <= state_d;
         done_rn_q  <= done_rn_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign stall_out             = stall_in | fifo_afull | fifo_full | (state_q != StRun);
   assign fb_valid              = fb_valid_q;
   assign fb_status             = fb_q.status;
   assign fb_read_num           = fb_q.read_num;
   assign fb_backward_i         = fb_q.backward_i;
   assign fb_backward_j         = fb_q.backward_j;
   assign fb_new_size           = fb_q.new_size;
   assign fb_new_last_size      = fb_q.new_last_size;
   assign fb_current_wr_addr    = fb_q.current_wr_addr;
   assign fb_mem_wr_addr        = fb_q.mem_wr_addr;
   assign fb_min_intv           = fb_q.min_intv;
   assign fb_iteration_boundary = fb_q.iteration_boundary;
   assign done_valid            = (state_q == StReport);
   assign done_read_num         = done_rn_q;
   assign done_count            = done_cnt_q;

endmodule

// File: tb/tb_smem_bck_writeback.sv
// Scoreboard bench for smem_bck_writeback; expectations follow BCK_WB_DEDUP_EN when defined.
module tb_smem_bck_writeback;
   localparam int DEPTH = 4;
   localparam logic [5:0] S_INI = 6'h04;
   localparam logic [5:0] S_RUN = 6'h05;
   localparam logic [5:0] S_END = 6'h06;
   localparam logic [5:0] S_BUB = 6'h30;

   logic clk = 1'b0;
   logic rst;
   logic stall_in, stall_out;
   logic [5:0] status_q;
   logic [8:0] read_num_q;
   logic [6:0] backward_i_q, backward_j_q, new_size_q, new_last_size_q;
   logic [6:0] current_wr_addr_q, mem_wr_addr_q, min_intv_q;
   logic finish_sign_q, iteration_boundary_q;
   logic [31:0] ext_k, ext_l, ext_s;
   logic fb_valid, fb_iteration_boundary;
   logic [5:0] fb_status;
   logic [8:0] fb_read_num;
   logic [6:0] fb_backward_i, fb_backward_j, fb_new_size, fb_new_last_size;
   logic [6:0] fb_current_wr_addr, fb_mem_wr_addr, fb_min_intv;
   logic done_valid, err_overflow;
   logic [8:0] done_read_num;
   logic [6:0] done_count;

   smem_bck_writeback_if #(.ADDR_W(7), .INTV_W(32)) wr_if ();

   smem_bck_writeback #(.FIFO_DEPTH(DEPTH), .ADDR_W(7), .INTV_W(32)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .stall_out(stall_out),
      .status_q(status_q), .read_num_q(read_num_q),
      .backward_i_q(backward_i_q), .backward_j_q(backward_j_q),
      .new_size_q(new_size_q), .new_last_size_q(new_last_size_q),
      .current_wr_addr_q(current_wr_addr_q), .mem_wr_addr_q(mem_wr_addr_q),
      .min_intv_q(min_intv_q), .finish_sign_q(finish_sign_q),
      .iteration_boundary_q(iteration_boundary_q),
      .ext_k(ext_k), .ext_l(ext_l), .ext_s(ext_s),
      .fb_valid(fb_valid), .fb_status(fb_status), .fb_read_num(fb_read_num),
      .fb_backward_i(fb_backward_i), .fb_backward_j(fb_backward_j),
      .fb_new_size(fb_new_size), .fb_new_last_size(fb_new_last_size),
      .fb_current_wr_addr(fb_current_wr_addr), .fb_mem_wr_addr(fb_mem_wr_addr),
      .fb_min_intv(fb_min_intv), .fb_iteration_boundary(fb_iteration_boundary),
      .wr_if(wr_if.master),
      .done_valid(done_valid), .done_read_num(done_read_num), .done_count(done_count),
      .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int wr_seen = 0;
   int done_seen = 0;
   logic [102:0] wr_q[$];
   logic [15:0]  done_q[$];
   logic exp_ovf = 1'b0;
   logic [31:0] m_last_s = '0;
   logic [8:0]  m_last_rn = '0;
   logic        m_last_vld = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      status_q = S_BUB; read_num_q = '0; new_size_q = '0; current_wr_addr_q = '0;
      min_intv_q = '0; finish_sign_q = 1'b0; iteration_boundary_q = 1'b0;
      ext_k = '0; ext_l = '0; ext_s = '0;
   endtask

   // Drive one token for a cycle, predict outputs, and queue expected writes/completions.
   task automatic send(input logic [5:0] st, input logic [8:0] rn, input logic [6:0] ns,
                       input logic [6:0] addr, input logic [6:0] minv, input logic [31:0] s,
                       input logic ib, input logic fin);
      logic keep;
      logic [6:0] ens, eaddr;
      logic vld;
      status_q = st; read_num_q = rn; new_size_q = ns; current_wr_addr_q = addr;
      min_intv_q = minv; ext_s = s; ext_k = s + 32'h100; ext_l = s + 32'h200;
      iteration_boundary_q = ib; finish_sign_q = fin;
      keep = (st == S_RUN) && (s >= {25'd0, minv}) && !ib;
`ifdef BCK_WB_DEDUP_EN
      if (keep && m_last_vld && m_last_rn == rn && m_last_s == s) keep = 1'b0;
      if (st == S_INI || ((st == S_RUN) && ib)) m_last_vld = 1'b0;
      else if (keep) begin m_last_s = s; m_last_rn = rn; m_last_vld = 1'b1; end
`endif
      ens   = keep ? ns + 7'd1 : ns;
      eaddr = keep ? addr - 7'd1 : addr;
      if (keep) begin
         if (wr_q.size() >= DEPTH && !wr_if.wr_ready) exp_ovf = 1'b1;
         else wr_q.push_back({addr, s + 32'h100, s + 32'h200, s});
      end
      if (st == S_RUN && fin) done_q.push_back({rn, ens});
      vld = (st == S_INI) || (st == S_RUN);
      tick();
      idle();
      check_eq("fb_valid", fb_valid, vld);
      if (vld) begin
         check_eq("fb_status", fb_status, st);
         check_eq("fb_read_num", fb_read_num, rn);
         check_eq("fb_new_size", fb_new_size, ens);
         check_eq("fb_cur_wr_addr", fb_current_wr_addr, eaddr);
         check_eq("fb_passthru", {fb_backward_j, fb_mem_wr_addr, fb_min_intv},
                  {backward_j_q, mem_wr_addr_q, minv});
      end else begin
         check_eq("fb_bubble_status", fb_status, S_BUB);
         check_eq("fb_bubble_size", fb_new_size, 7'd0);
      end
      check_eq("err_overflow", err_overflow, exp_ovf);
   endtask

   always @(negedge clk) begin
      if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
         wr_seen++;
         if (wr_q.size() == 0) check_eq("wr_unexpected", {wr_if.wr_addr, wr_if.wr_data}, '0);
         else check_eq("wr_entry", {wr_if.wr_addr, wr_if.wr_data}, wr_q.pop_front());
      end
      if (done_valid === 1'b1) begin
         done_seen++;
         if (done_q.size() == 0) check_eq("done_unexpected", {done_read_num, done_count}, '0);
         else check_eq("done_entry", {done_read_num, done_count}, done_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, d0;
      backward_i_q = 7'd11; backward_j_q = 7'd22; new_last_size_q = 7'd33; mem_wr_addr_q = 7'd44;
      stall_in = 1'b0; wr_if.wr_ready = 1'b1; idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_fb_status", fb_status, S_BUB);
      check_eq("rst_fb_valid", fb_valid, 1'b0);
      check_eq("rst_wr_valid", wr_if.wr_valid, 1'b0);
      check_eq("rst_err_ovf", err_overflow, 1'b0);
      check_eq("rst_misc", {stall_out, done_valid, fb_new_size}, '0);

      send(S_BUB, 9'd0, 7'd0, 7'd0, 7'd0, 32'd0, 1'b0, 1'b0);
      send(S_INI, 9'd3, 7'd3, 7'd20, 7'd5, 32'd1, 1'b0, 1'b0);
      send(S_RUN, 9'd1, 7'd3, 7'd20, 7'd5, 32'd10, 1'b0, 1'b0);
      check_eq("keep_new_size", fb_new_size, 7'd4);
      check_eq("keep_cur_addr", fb_current_wr_addr, 7'd19);
      check_eq("keep_wr_head", {wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data[31:0]},
               {1'b1, 7'd20, 32'd10});
      send(S_RUN, 9'd1, 7'd3, 7'd20, 7'd5, 32'd4, 1'b0, 1'b0);
      check_eq("drop_new_size", fb_new_size, 7'd3);

      // Stalled token must be ignored and fb held.
      stall_in = 1'b1;
      status_q = S_RUN; read_num_q = 9'd1; new_size_q = 7'd9; current_wr_addr_q = 7'd10;
      min_intv_q = 7'd5; ext_s = 32'd50;
      tick();
      idle();
      check_eq("stall_hold", {fb_valid, fb_new_size, fb_current_wr_addr}, {1'b1, 7'd3, 7'd20});
      check_eq("stall_out_stalled", stall_out, 1'b1);
      stall_in = 1'b0;

      send(S_RUN, 9'd1, 7'd3, 7'd0, 7'd5, 32'd11, 1'b0, 1'b0);
      check_eq("wrap_cur_addr", fb_current_wr_addr, 7'd127);
      send(S_RUN, 9'd1, 7'd3, 7'd15, 7'd5, 32'd60, 1'b1, 1'b0);
      check_eq("ib_drop_size", fb_new_size, 7'd3);
      send(S_END, 9'd1, 7'd3, 7'd15, 7'd5, 32'd60, 1'b0, 1'b0);

      // Backpressure and overflow.
      tick();
      wr_if.wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(S_RUN, 9'd2, 7'(i), 7'(50 - i), 7'd5, 32'(20 + i), 1'b0, 1'b0);
         if (i == 1) check_eq("bp_stall_cnt2", stall_out, 1'b0);
         if (i == 2) check_eq("bp_stall_cnt3", stall_out, 1'b1);
      end
      check_eq("ovf_set", err_overflow, 1'b1);
      wr_if.wr_ready = 1'b1;
      for (int i = 0; i < 20 && wr_q.size() != 0; i++) tick();
      check_eq("bp_drain_timeout", wr_q.size(), 0);
      tick();
      check_eq("bp_after_drain", {wr_if.wr_valid, stall_out, err_overflow}, 3'b001);

      // Finish with drain.
      wr_if.wr_ready = 1'b0;
      send(S_RUN, 9'd7, 7'd0, 7'd40, 7'd5, 32'd30, 1'b0, 1'b0);
      send(S_RUN, 9'd7, 7'd1, 7'd39, 7'd5, 32'd31, 1'b0, 1'b1);
      check_eq("fin_stall", stall_out, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("drain_stall", stall_out, 1'b1);
         check_eq("drain_no_done", done_seen, 0);
      end
      wr_if.wr_ready = 1'b1;
      for (int i = 0; i < 30 && done_seen == 0; i++) tick();
      check_eq("done_timeout", done_seen, 1);
      tick(); tick(); tick();
      check_eq("done_single", done_seen, 1);
      check_eq("post_report", {stall_out, done_valid}, 2'b00);

      // Reset in the middle of a drain: no completion pulse.
      wr_if.wr_ready = 1'b0;
      send(S_RUN, 9'd5, 7'd0, 7'd60, 7'd5, 32'd40, 1'b0, 1'b1);
      tick();
      check_eq("rd_stall", stall_out, 1'b1);
      wr_q.delete(); done_q.delete(); exp_ovf = 1'b0; m_last_vld = 1'b0;
      d0 = done_seen;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_if.wr_ready = 1'b1;
      check_eq("rd_fb_status", fb_status, S_BUB);
      check_eq("rd_clear", {fb_valid, wr_if.wr_valid, stall_out, err_overflow}, 4'b0000);
      repeat (6) tick();
      check_eq("rd_no_done", done_seen, d0);

      // Duplicate keeps within one iteration.
      w0 = wr_seen;
      send(S_INI, 9'd9, 7'd0, 7'd30, 7'd5, 32'd0, 1'b0, 1'b0);
      send(S_RUN, 9'd9, 7'd0, 7'd30, 7'd5, 32'd12, 1'b0, 1'b0);
      send(S_RUN, 9'd9, 7'd1, 7'd29, 7'd5, 32'd12, 1'b0, 1'b0);
`ifdef BCK_WB_DEDUP_EN
      check_eq("dup_size", fb_new_size, 7'd1);
      repeat (4) tick();
      check_eq("dup_writes", wr_seen - w0, 1);
`else
      check_eq("dup_size", fb_new_size, 7'd2);
      repeat (4) tick();
      check_eq("dup_writes", wr_seen - w0, 2);
`endif
      check_eq("wr_q_empty", wr_q.size(), 0);
      check_eq("done_q_empty", done_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
